// File: rtl/sample_serializer_pkg.sv
// Shared audio constants for the I2S sample serializer.
package sample_serializer_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int FRAME_BITS = 32;
    localparam int SLOT_BITS  = 16;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int BIT_IDX_W  = $clog2(SLOT_BITS);

    // Bit of cur sent when entering slot position k: (-k) mod 16 covers
    // the left slot, the right slot and the delayed LSB at k = 0.
    function automatic logic [BIT_IDX_W-1:0] slot_bit_idx(input logic [BIT_CNT_W-1:0] k);
        return BIT_IDX_W'(0) - k[BIT_IDX_W-1:0];
    endfunction

endpackage

// File: rtl/sample_serializer_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_DIV cycles and flags the 1->0 toggle.
module bclk_gen #(
    parameter int BCLK_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic bclk_o,
    output logic fall_o
);

    localparam int CNT_W = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    logic             wrap;

    always_comb begin
        wrap      = (div_cnt_q == CNT_MAX);
        div_cnt_d = wrap ? '0 : div_cnt_q + CNT_W'(1);
        bclk_d    = wrap ? ~bclk_q : bclk_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o = bclk_q;
    // High in the cycle whose closing edge drives bclk low.
    assign fall_o = wrap & bclk_q;

endmodule

// File: rtl/sample_serializer.sv
// Mono I2S serializer: one-entry holding register feeding a 32-bit frame,
// same sample in both slots, with overrun/underrun pulses.
module sample_serializer
    import sample_serializer_pkg::*;
#(
    parameter int BCLK_DIV = 16
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic [SAMPLE_W-1:0] data_in,
    input  logic                data_valid_in,
    output logic                bclk_out,
    output logic                lrclk_out,
    output logic                sdata_out,
    output logic                overrun_out,
    output logic                underrun_out
);

    logic                 fall;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BIT_CNT_W-1:0] k;
    logic [SAMPLE_W-1:0]  cur_q, cur_d;
    logic [SAMPLE_W-1:0]  hold_q, hold_d;
    logic                 full_q, full_d;
    logic                 lrclk_q, lrclk_d;
    logic                 sdata_q, sdata_d;
    logic                 overrun_q, overrun_d;
    logic                 underrun_q, underrun_d;
    logic                 reload;

    bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
        .clk_i   (clk_in),
        .rst_n_i (reset_in),
        .bclk_o  (bclk_out),
        .fall_o  (fall)
    );

    always_comb begin
        k          = bit_cnt_q + BIT_CNT_W'(1);
        reload     = fall && (k == '0);
        bit_cnt_d  = bit_cnt_q;
        cur_d      = cur_q;
        hold_d     = hold_q;
        full_d     = full_q;
        lrclk_d    = lrclk_q;
        sdata_d    = sdata_q;
        overrun_d  = 1'b0;
        underrun_d = 1'b0;

        if (fall) begin
            bit_cnt_d = k;
            lrclk_d   = (k >= BIT_CNT_W'(SLOT_BITS));
            sdata_d   = cur_q[slot_bit_idx(k)];
        end

        if (reload) begin
            if (full_q) begin
                cur_d  = hold_q;
                full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // full_d already reflects a same-cycle reload, so a coinciding strobe
        // refills the freed slot instead of counting as an overrun.
        if (data_valid_in) begin
            overrun_d = full_d;
            hold_d    = data_in;
            full_d    = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            bit_cnt_q  <= '1;
            cur_q      <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            sdata_q    <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            cur_q      <= cur_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            lrclk_q    <= lrclk_d;
            sdata_q    <= sdata_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign lrclk_out    = lrclk_q;
    assign sdata_out    = sdata_q;
    assign overrun_out  = overrun_q;
    assign underrun_out = underrun_q;

endmodule

// File: tb/tb_sample_serializer.sv
// Self-checking bench for sample_serializer with BCLK_DIV = 2 and a frame-level model.
module tb_sample_serializer;

    localparam int D    = 2;
    localparam int NFRM = 16;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic        data_valid_in = 1'b0;
    logic        bclk_out, lrclk_out, sdata_out, overrun_out, underrun_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk_in = ~clk_in;

    sample_serializer #(.BCLK_DIV(D)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .data_in       (data_in),
        .data_valid_in (data_valid_in),
        .bclk_out      (bclk_out),
        .lrclk_out     (lrclk_out),
        .sdata_out     (sdata_out),
        .overrun_out   (overrun_out),
        .underrun_out  (underrun_out)
    );

    // Reference model: fall events happen every 2*D cycles after release;
    // each frame start sends the held sample if one is waiting.
    int          cyc;
    logic [15:0] m_cur, m_hold;
    bit          m_full;
    int          exp_under, exp_over;
    logic [15:0] m_sent [NFRM];

    initial forever begin
        @(posedge clk_in or negedge reset_in);
        if (!reset_in) begin
            cyc = 0; m_cur = '0; m_hold = '0; m_full = 0;
            exp_under = 0; exp_over = 0;
            for (int i = 0; i < NFRM; i++) m_sent[i] = '0;
        end else begin
            cyc++;
            if (cyc % (2 * D) == 0) begin
                int n;
                n = cyc / (2 * D) - 1;
                if (n % 32 == 0) begin
                    if (m_full) begin m_cur = m_hold; m_full = 0; end
                    else exp_under++;
                    if (n / 32 < NFRM) m_sent[n / 32] = m_cur;
                end
            end
            if (data_valid_in) begin
                if (m_full) exp_over++;
                m_hold = data_in;
                m_full = 1;
            end
        end
    end

    // Monitor: captures the serial stream at each observed bclk fall.
    int          mon_nf, under_cnt, over_cnt, under_k0, pre_nonzero, lr_glitch;
    int          first_rise, first_fall, second_fall;
    bit          prev_bclk, prev_lr;
    logic [15:0] cap_left  [NFRM];
    logic [15:0] cap_right [NFRM];
    logic [31:0] lr_bits   [NFRM];

    initial forever begin
        @(negedge clk_in);
        if (!reset_in) begin
            mon_nf = 0; under_cnt = 0; over_cnt = 0; under_k0 = 0;
            pre_nonzero = 0; lr_glitch = 0;
            first_rise = -1; first_fall = -1; second_fall = -1;
            prev_bclk = 0; prev_lr = 0;
            for (int i = 0; i < NFRM; i++) begin
                cap_left[i] = '0; cap_right[i] = '0; lr_bits[i] = '0;
            end
        end else begin
            bit fell;
            fell = prev_bclk && !bclk_out;
            if (!prev_bclk && bclk_out && first_rise < 0) first_rise = cyc;
            if (mon_nf == 0 && !fell && (lrclk_out || sdata_out)) pre_nonzero++;
            if (fell) begin
                int k, f;
                k = mon_nf % 32;
                f = mon_nf / 32;
                if (first_fall < 0) first_fall = cyc;
                else if (second_fall < 0) second_fall = cyc;
                if (f < NFRM) begin
                    lr_bits[f][k] = lrclk_out;
                    if (k >= 1 && k <= 16) cap_left[f][16 - k] = sdata_out;
                    else if (k >= 17) cap_right[f][32 - k] = sdata_out;
                end
                if (k == 0 && f > 0 && f <= NFRM) cap_right[f - 1][0] = sdata_out;
                if (k == 0 && underrun_out) under_k0++;
                mon_nf++;
            end else if (lrclk_out != prev_lr) begin
                lr_glitch++;
            end
            if (underrun_out) under_cnt++;
            if (overrun_out) over_cnt++;
            prev_lr   = lrclk_out;
            prev_bclk = bclk_out;
        end
    end

    task automatic do_reset();
        @(negedge clk_in);
        reset_in = 1'b0;
        data_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        @(posedge clk_in);
        #2 reset_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic strobe(input logic [15:0] d);
        data_in = d;
        data_valid_in = 1'b1;
        @(negedge clk_in);
        data_valid_in = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 20000) begin
            @(negedge clk_in);
            guard++;
        end
        if (cyc != c) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_cyc timeout: cycle %0d, wanted %0d", cyc, c);
        end
    endtask

    task automatic run_until(input int nf);
        int guard;
        guard = 0;
        while (mon_nf < nf && guard < 20000) begin
            @(negedge clk_in);
            guard++;
        end
        if (mon_nf < nf) begin
            n_cmp++; n_fail++;
            $display("FAIL run_until timeout: falls %0d, wanted %0d", mon_nf, nf);
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_reset();
        do_reset();
        run_until(33);
        n_cmp++; if (first_rise !== 2 * D / 2 + D / 2 && first_rise !== D) begin n_fail++; $display("FAIL first_rise: got %0d want %0d", first_rise, D); end
        n_cmp++; if (first_fall !== 2 * D) begin n_fail++; $display("FAIL first_fall: got %0d want %0d", first_fall, 2 * D); end
        n_cmp++; if (second_fall - first_fall !== 2 * D) begin n_fail++; $display("FAIL bclk_period: got %0d want %0d", second_fall - first_fall, 2 * D); end
        n_cmp++; if (pre_nonzero !== 0) begin n_fail++; $display("FAIL pre_first_fall_zero: got %0d nonzero cycles want 0", pre_nonzero); end
        n_cmp++; if (cap_left[0] !== 16'h0 || cap_right[0] !== 16'h0) begin n_fail++; $display("FAIL first_frame_sdata: got %h/%h want 0000/0000", cap_left[0], cap_right[0]); end
        n_cmp++; if (under_cnt !== exp_under) begin n_fail++; $display("FAIL reset_underruns: got %0d want %0d", under_cnt, exp_under); end
    endtask

    task automatic test_basic();
        do_reset();
        strobe(16'hA5C3);
        run_until(33);
        n_cmp++; if (cap_left[0] !== 16'hA5C3) begin n_fail++; $display("FAIL basic_left: got %h want a5c3", cap_left[0]); end
        n_cmp++; if (cap_right[0][15:1] !== 15'(16'hA5C3 >> 1)) begin n_fail++; $display("FAIL basic_right: got %h want %h", cap_right[0][15:1], 15'(16'hA5C3 >> 1)); end
        n_cmp++; if (cap_right[0][0] !== 1'b1) begin n_fail++; $display("FAIL basic_k0_bit: got %b want 1", cap_right[0][0]); end
        n_cmp++; if (cap_left[0] !== m_sent[0]) begin n_fail++; $display("FAIL basic_model: got %h want %h", cap_left[0], m_sent[0]); end
    endtask

    task automatic test_lrclk();
        logic [31:0] exp_lr;
        do_reset();
        strobe(16'($urandom));
        run_until(65);
        for (int k = 0; k < 32; k++) exp_lr[k] = (k >= 16);
        n_cmp++; if (lr_bits[0] !== exp_lr) begin n_fail++; $display("FAIL lrclk_frame0: got %h want %h", lr_bits[0], exp_lr); end
        n_cmp++; if (lr_bits[1] !== exp_lr) begin n_fail++; $display("FAIL lrclk_frame1: got %h want %h", lr_bits[1], exp_lr); end
        n_cmp++; if (lr_glitch !== 0) begin n_fail++; $display("FAIL lrclk_off_fall_change: got %0d want 0", lr_glitch); end
    endtask

    task automatic test_underrun();
        do_reset();
        strobe(16'h8001);
        run_until(33);
        n_cmp++; if (under_cnt !== 1 || under_k0 !== 1) begin n_fail++; $display("FAIL underrun_pulse: got %0d (at k0 %0d) want 1", under_cnt, under_k0); end
        run_until(65);
        n_cmp++; if (cap_left[1] !== 16'h8001 || cap_right[1] !== 16'h8001) begin n_fail++; $display("FAIL underrun_resend: got %h/%h want 8001/8001", cap_left[1], cap_right[1]); end
        n_cmp++; if (under_cnt !== exp_under) begin n_fail++; $display("FAIL underrun_model: got %0d want %0d", under_cnt, exp_under); end
    endtask

    task automatic test_overrun();
        do_reset();
        strobe(16'($urandom));
        wait_cyc(10);
        strobe(16'h1111);
        wait_cyc(60);
        strobe(16'h2222);
        run_until(65);
        n_cmp++; if (over_cnt !== 1) begin n_fail++; $display("FAIL overrun_pulse: got %0d want 1", over_cnt); end
        n_cmp++; if (cap_left[1] !== 16'h2222 || cap_right[1] !== 16'h2222) begin n_fail++; $display("FAIL overrun_data: got %h/%h want 2222/2222", cap_left[1], cap_right[1]); end
        n_cmp++; if (over_cnt !== exp_over) begin n_fail++; $display("FAIL overrun_model: got %0d want %0d", over_cnt, exp_over); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        strobe(16'h5555);
        wait_cyc(20);
        strobe(16'h3333);
        wait_cyc(2 * D * 33 - 1);
        strobe(16'h4444);
        run_until(97);
        n_cmp++; if (cap_left[1] !== 16'h3333 || cap_right[1] !== 16'h3333) begin n_fail++; $display("FAIL coincide_first: got %h/%h want 3333/3333", cap_left[1], cap_right[1]); end
        n_cmp++; if (cap_left[2] !== 16'h4444 || cap_right[2] !== 16'h4444) begin n_fail++; $display("FAIL coincide_second: got %h/%h want 4444/4444", cap_left[2], cap_right[2]); end
        n_cmp++; if (over_cnt !== 0) begin n_fail++; $display("FAIL coincide_no_overrun: got %0d want 0", over_cnt); end
        n_cmp++; if (m_sent[1] !== 16'h3333 || m_sent[2] !== 16'h4444) begin n_fail++; $display("FAIL coincide_model_sent: got %h/%h want 3333/4444", m_sent[1], m_sent[2]); end
    endtask

    task automatic test_abort();
        do_reset();
        strobe(16'hFFFF);
        run_until(20);
        #2 reset_in = 1'b0;
        #1;
        n_cmp++; if ({bclk_out, lrclk_out, sdata_out, overrun_out, underrun_out} !== 5'b0) begin n_fail++; $display("FAIL reset_outputs: got %b want 00000", {bclk_out, lrclk_out, sdata_out, overrun_out, underrun_out}); end
        @(negedge clk_in);
        @(posedge clk_in);
        #2 reset_in = 1'b1;
        @(negedge clk_in);
        run_until(33);
        n_cmp++; if (cap_left[0] !== 16'h0 || cap_right[0] !== 16'h0) begin n_fail++; $display("FAIL abort_cur_cleared: got %h/%h want 0000/0000", cap_left[0], cap_right[0]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1200; c++) begin
            data_valid_in = ($urandom_range(0, 49) == 0);
            data_in = 16'($urandom);
            @(negedge clk_in);
        end
        data_valid_in = 1'b0;
        run_until(321);
        for (int f = 0; f < 10; f++) begin
            n_cmp++; if (cap_left[f] !== m_sent[f]) begin n_fail++; $display("FAIL random_left[%0d]: got %h want %h", f, cap_left[f], m_sent[f]); end
            n_cmp++; if (cap_right[f] !== m_sent[f]) begin n_fail++; $display("FAIL random_right[%0d]: got %h want %h", f, cap_right[f], m_sent[f]); end
        end
        n_cmp++; if (over_cnt !== exp_over) begin n_fail++; $display("FAIL random_overruns: got %0d want %0d", over_cnt, exp_over); end
        n_cmp++; if (under_cnt !== exp_under) begin n_fail++; $display("FAIL random_underruns: got %0d want %0d", under_cnt, exp_under); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lrclk();
        test_underrun();
        test_overrun();
        test_back_to_back();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
